// File: rtl/ext_unit.sv
// Immediate extender: widens an instruction immediate to OUT_W bits using one of
// four modes (sign, zero, load-upper, sign-then-shift-left-2), with one registered stage.
module ext_unit #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32   // must be 2*IMM_W so load-upper fills the word exactly
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       EOp,
  output logic [OUT_W-1:0] ext,
  output logic             out_valid
);

  // Handshake: in_valid qualifies imm/EOp for exactly one cycle and is always accepted
  // (no ready, no backpressure); out_valid pulses for one cycle, one edge later, per
  // accepted input. Without in_valid, ext keeps its last value while out_valid is low.

  localparam logic [1:0] EOP_SIGN  = 2'b00;
  localparam logic [1:0] EOP_ZERO  = 2'b01;
  localparam logic [1:0] EOP_UPPER = 2'b10;
  localparam logic [1:0] EOP_BRANCH = 2'b11;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_d;
  logic [OUT_W-1:0] ext_q;
  logic             valid_q;

  assign sext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    ext_d = '0;
    case (EOp)
      EOP_SIGN:   ext_d = sext;
      EOP_ZERO:   ext_d = {{(OUT_W-IMM_W){1'b0}}, imm};
      EOP_UPPER:  ext_d = {imm, {(OUT_W-IMM_W){1'b0}}};
      // Branch offset: the two top sign bits fall off the word.
      EOP_BRANCH: ext_d = {sext[OUT_W-3:0], 2'b00};
      default:    ext_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        ext_q <= ext_d;
      end
    end
  end

  assign ext       = ext_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ext_unit.sv
// Self-checking bench for ext_unit: hand-computed directed vectors, then a random
// sweep with in_valid gaps and a mid-stream reset checked against a reference model.
module tb_ext_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] imm;
  logic [1:0]  EOp;
  logic [31:0] ext;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_ext;
  logic        model_valid;

  ext_unit #(.IMM_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .imm       (imm),
    .EOp       (EOp),
    .ext       (ext),
    .out_valid (out_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, want);
    end
  endtask

  // Reference written with signed arithmetic rather than bit concatenation.
  function automatic logic [31:0] ref_ext(input logic [15:0] im, input logic [1:0] op);
    logic signed [31:0] s;
    logic [31:0] r;
    s = 32'(signed'(im));
    case (op)
      2'd0:    r = s;
      2'd1:    r = 32'(im);
      2'd2:    r = 32'(im) * 32'd65536;
      default: r = s * 4;
    endcase
    return r;
  endfunction

  // Driver: apply one cycle of inputs, advance past the edge, update the model and
  // compare both outputs.
  task automatic cycle(input logic r, input logic v, input logic [15:0] im, input logic [1:0] op);
    reset    = r;
    in_valid = v;
    imm      = im;
    EOp      = op;
    @(posedge clk);
    #1;
    if (r) begin
      model_ext   = 32'h0;
      model_valid = 1'b0;
    end else if (v) begin
      model_ext   = ref_ext(im, op);
      model_valid = 1'b1;
    end else begin
      model_valid = 1'b0;
    end
    check("out_valid", {31'b0, out_valid}, {31'b0, model_valid});
    check("ext", ext, model_ext);
  endtask

  // Directed vector: drive it and also compare against the hand-computed constant.
  task automatic directed(input string tag, input logic [15:0] im, input logic [1:0] op,
                          input logic [31:0] want);
    exp_q.push_back(want);
    cycle(1'b0, 1'b1, im, op);
    check(tag, ext, exp_q.pop_front());
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
  endtask

  logic [31:0] held;

  initial begin
    model_ext   = 32'h0;
    model_valid = 1'b0;
    reset = 1'b1; in_valid = 1'b0; imm = 16'h0; EOp = 2'b00;

    // Reset held two cycles, then in_valid during reset must be ignored.
    cycle(1'b1, 1'b0, 16'h0000, 2'b00);
    cycle(1'b1, 1'b0, 16'h0000, 2'b00);
    check("rst_ext", ext, 32'h0000_0000);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    cycle(1'b1, 1'b1, 16'h8001, 2'b00);
    check("rst_over_valid", {31'b0, out_valid}, 32'h0);
    check("rst_over_ext", ext, 32'h0000_0000);

    // imm = 0x8001 in all modes, back to back
    directed("m00_8001", 16'h8001, 2'b00, 32'hFFFF_8001);
    directed("m01_8001", 16'h8001, 2'b01, 32'h0000_8001);
    directed("m10_8001", 16'h8001, 2'b10, 32'h8001_0000);
    directed("m11_8001", 16'h8001, 2'b11, 32'hFFFE_0004);

    // imm = 0x7FFF
    directed("m00_7fff", 16'h7FFF, 2'b00, 32'h0000_7FFF);
    directed("m11_7fff", 16'h7FFF, 2'b11, 32'h0001_FFFC);
    directed("m10_7fff", 16'h7FFF, 2'b10, 32'h7FFF_0000);

    // Boundaries
    directed("m11_ffff", 16'hFFFF, 2'b11, 32'hFFFF_FFFC);
    directed("m01_ffff", 16'hFFFF, 2'b01, 32'h0000_FFFF);
    directed("m00_0000", 16'h0000, 2'b00, 32'h0000_0000);
    directed("m01_0000", 16'h0000, 2'b01, 32'h0000_0000);
    directed("m10_0000", 16'h0000, 2'b10, 32'h0000_0000);
    directed("m11_0000", 16'h0000, 2'b11, 32'h0000_0000);

    // Hold behaviour: valid result, then 3 idle cycles, then a 1-cycle reset.
    directed("pre_hold", 16'h1234, 2'b10, 32'h1234_0000);
    held = 32'h1234_0000;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 16'hABCD, 2'b01);
      check("hold_ext", ext, held);
      check("hold_valid", {31'b0, out_valid}, 32'h0);
    end
    cycle(1'b1, 1'b0, 16'h0000, 2'b00);
    check("post_rst_ext", ext, 32'h0000_0000);

    // Random sweep with gaps and a mid-stream reset
    for (int i = 0; i < 1000; i++) begin
      logic r, v;
      logic [15:0] im;
      logic [1:0]  op;
      r  = (i == 500);
      v  = ($urandom_range(0, 3) != 0);
      im = 16'($urandom_range(0, 65535));
      op = 2'($urandom_range(0, 3));
      cycle(r, v, im, op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
